// File: rtl/button_conditioner.sv
// Push-button conditioner: per-channel 2-FF synchroniser, counter debouncer,
// press/release strobes and hold auto-repeat. All outputs are registered.
module button_conditioner #(
   parameter int NUM_BUTTONS         = 3,
   parameter int DEBOUNCE_CYCLES     = 1_000_000,
   parameter int REPEAT_DELAY_CYCLES = 25_000_000,
   parameter int REPEAT_RATE_CYCLES  = 5_000_000,
   parameter bit KEY_ACTIVE_LOW      = 1'b1
) (
   input  logic                   clk_clk,
   input  logic                   reset_reset_n,
   input  logic [NUM_BUTTONS-1:0] key_raw,
   output logic [NUM_BUTTONS-1:0] buttons_export,
   output logic [NUM_BUTTONS-1:0] press_pulse,
   output logic [NUM_BUTTONS-1:0] release_pulse,
   output logic [NUM_BUTTONS-1:0] repeat_pulse
);

   localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_MAX = ((REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                              REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES) - 1;
   localparam int HOLD_W   = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

   localparam logic [DB_W-1:0]        DB_ONE     = DB_W'(1);
   localparam logic [DB_W-1:0]        DB_DONE    = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [HOLD_W-1:0]      HOLD_ONE   = HOLD_W'(1);
   localparam logic [HOLD_W-1:0]      DELAY_LAST = HOLD_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [HOLD_W-1:0]      RATE_LAST  = HOLD_W'(REPEAT_RATE_CYCLES - 1);
   localparam logic [NUM_BUTTONS-1:0] IDLE_LVL   = {NUM_BUTTONS{KEY_ACTIVE_LOW}};

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_PEND,
      PRESSED,
      RELEASE_PEND
   } state_e;

   logic [NUM_BUTTONS-1:0] sync1_q, sync1_d;
   logic [NUM_BUTTONS-1:0] sync2_q, sync2_d;
   logic [NUM_BUTTONS-1:0] pressed_s;

   always_comb begin
      sync1_d   = key_raw;
      sync2_d   = sync1_q;
      pressed_s = sync2_q ^ IDLE_LVL;
   end

   // NOTE: reset is sampled on the clock edge, so it lives inside the
   // clocked branch; sequential state is always written with <=.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         sync1_q <= IDLE_LVL;
         sync2_q <= IDLE_LVL;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
      state_e            state_q, state_d;
      logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
      logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
      logic              first_done_q, first_done_d;
      logic              level_q, level_d;
      logic              press_q, press_d;
      logic              release_q, release_d;
      logic              repeat_q, repeat_d;
      logic              s;

      // NOTE: every always_comb output gets a default first so no path
      // leaves a variable unassigned and infers a latch.
      always_comb begin
         s         = pressed_s[g];
         state_d   = state_q;
         db_cnt_d  = db_cnt_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         unique case (state_q)
            RELEASED: begin
               if (s) begin
                  state_d  = PRESS_PEND;
                  db_cnt_d = DB_ONE;
               end
            end
            PRESS_PEND: begin
               if (!s) begin
                  state_d  = RELEASED;
                  db_cnt_d = '0;
               end else if (db_cnt_q == DB_DONE) begin
                  state_d  = PRESSED;
                  db_cnt_d = '0;
                  press_d  = 1'b1;
               end else begin
                  db_cnt_d = db_cnt_q + DB_ONE;
               end
            end
            PRESSED: begin
               if (!s) begin
                  state_d  = RELEASE_PEND;
                  db_cnt_d = DB_ONE;
               end
            end
            RELEASE_PEND: begin
               if (s) begin
                  state_d  = PRESSED;
                  db_cnt_d = '0;
               end else if (db_cnt_q == DB_DONE) begin
                  state_d   = RELEASED;
                  db_cnt_d  = '0;
                  release_d = 1'b1;
               end else begin
                  db_cnt_d = db_cnt_q + DB_ONE;
               end
            end
            default: begin
               state_d  = RELEASED;
               db_cnt_d = '0;
            end
         endcase

         level_d = (state_d == PRESSED) || (state_d == RELEASE_PEND);

         // Hold timer runs only while the committed level is pressed; a
         // release commit clears it and swallows any repeat due that cycle.
         hold_cnt_d   = hold_cnt_q;
         first_done_d = first_done_q;
         repeat_d     = 1'b0;
         if (!level_q || release_d) begin
            hold_cnt_d   = '0;
            first_done_d = 1'b0;
         end else if (hold_cnt_q == (first_done_q ? RATE_LAST : DELAY_LAST)) begin
            hold_cnt_d   = '0;
            first_done_d = 1'b1;
            repeat_d     = 1'b1;
         end else begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
         end
      end

      always_ff @(posedge clk_clk) begin
         if (!reset_reset_n) begin
            state_q      <= RELEASED;
            db_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            first_done_q <= 1'b0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            repeat_q     <= 1'b0;
         end else begin
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            first_done_q <= first_done_d;
            level_q      <= level_d;
            press_q      <= press_d;
            release_q    <= release_d;
            repeat_q     <= repeat_d;
         end
      end

      assign buttons_export[g] = level_q;
      assign press_pulse[g]    = press_q;
      assign release_pulse[g]  = release_q;
      assign repeat_pulse[g]   = repeat_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with literal expectations
// plus randomized key activity compared every cycle against a run-length model.
module tb_button_conditioner;

   localparam int N  = 3;
   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RR = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] key_raw = '1;
   logic [N-1:0] buttons_export, press_pulse, release_pulse, repeat_pulse;

   int checks = 0;
   int errors = 0;

   button_conditioner #(
      .NUM_BUTTONS         (N),
      .DEBOUNCE_CYCLES     (DB),
      .REPEAT_DELAY_CYCLES (RD),
      .REPEAT_RATE_CYCLES  (RR),
      .KEY_ACTIVE_LOW      (1'b1)
   ) dut (
      .clk_clk        (clk),
      .reset_reset_n  (rst_n),
      .key_raw        (key_raw),
      .buttons_export (buttons_export),
      .press_pulse    (press_pulse),
      .release_pulse  (release_pulse),
      .repeat_pulse   (repeat_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a level flips once the synchronised sample has disagreed with it
   // for DB+1 consecutive edges; repeats are scheduled by elapsed hold time.
   bit           m_h1 [N];
   bit           m_h2 [N];
   bit           m_lvl[N];
   int           m_run[N];
   int           m_t  [N];
   logic [N-1:0] m_exp, m_press, m_rel, m_rep;
   bit           m_valid = 1'b0;

   always @(posedge clk) begin
      bit s;
      for (int i = 0; i < N; i++) begin
         m_press[i] = 1'b0;
         m_rel[i]   = 1'b0;
         m_rep[i]   = 1'b0;
         if (!rst_n) begin
            m_h1[i]  = 1'b0;
            m_h2[i]  = 1'b0;
            m_lvl[i] = 1'b0;
            m_run[i] = 0;
            m_t[i]   = 0;
         end else begin
            s        = m_h2[i];
            m_h2[i]  = m_h1[i];
            m_h1[i]  = ~key_raw[i];
            m_run[i] = (s != m_lvl[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == DB + 1) begin
               m_lvl[i] = s;
               m_run[i] = 0;
               if (s) begin
                  m_press[i] = 1'b1;
                  m_t[i]     = 0;
               end else begin
                  m_rel[i] = 1'b1;
               end
            end else if (m_lvl[i]) begin
               m_t[i]++;
               m_rep[i] = (m_t[i] == RD) || (m_t[i] > RD && (m_t[i] - RD) % RR == 0);
            end
         end
         m_exp[i] = m_lvl[i];
      end
      m_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("model level",   buttons_export, m_exp);
         check("model press",   press_pulse,    m_press);
         check("model release", release_pulse,  m_rel);
         check("model repeat",  repeat_pulse,   m_rep);
      end
   end

   task automatic drive(input logic [N-1:0] v);
      @(negedge clk);
      #1 key_raw = v;
   endtask

   int p, first_rep, last_rep, rep_cnt, cnt, rk;
   int rate;

   initial begin
      rst_n   = 1'b0;
      key_raw = '1;
      repeat (3) @(negedge clk);
      check("reset outputs", {buttons_export, press_pulse, release_pulse, repeat_pulse}, 0);
      #1 rst_n = 1'b1;

      // 1: clean press on key 0
      drive(3'b110);
      repeat (6) @(negedge clk);
      check("t1 no early press", press_pulse, 0);
      @(negedge clk);
      check("t1 press", press_pulse, 3'b001);
      check("t1 level", buttons_export, 3'b001);
      @(negedge clk);
      check("t1 press one cycle", press_pulse, 0);
      drive(3'b111);
      repeat (10) @(negedge clk);

      // 2: 3-cycle glitch on key 1
      drive(3'b101);
      repeat (2) @(negedge clk);
      drive(3'b111);
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         cnt += int'(press_pulse[1] | release_pulse[1] | buttons_export[1]);
      end
      check("t2 glitch ignored", cnt, 0);

      // 3: hold key 2 for 60 cycles
      drive(3'b011);
      p = -1; first_rep = -1; last_rep = -1; rep_cnt = 0;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (press_pulse[2]) p = k;
         if (repeat_pulse[2]) begin
            rep_cnt++;
            if (first_rep < 0) first_rep = k;
            last_rep = k;
         end
         if (k == 60) #1 key_raw = 3'b111;
      end
      check("t3 press cycle", p, 7);
      check("t3 repeat count", rep_cnt, 5);
      check("t3 first repeat", first_rep - p, 20);
      check("t3 last repeat", last_rep - p, 52);

      // 4: release with a 2-cycle re-press bounce
      drive(3'b110);
      repeat (12) @(negedge clk);
      drive(3'b111);
      @(negedge clk);
      drive(3'b110);
      @(negedge clk);
      drive(3'b111);
      cnt = 0; rk = -1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (release_pulse[0]) begin
            cnt++;
            rk = k + 4;
         end
      end
      check("t4 release count", cnt, 1);
      check("t4 release latency", rk - 4, 7);

      // 5: all keys on the same edge
      drive(3'b000);
      repeat (6) @(negedge clk);
      @(negedge clk);
      check("t5 press all", press_pulse, 3'b111);
      @(negedge clk);
      check("t5 press clears", press_pulse, 3'b000);

      // 6: reset while held
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("t6 reset outputs", {buttons_export, press_pulse, release_pulse, repeat_pulse}, 0);
      @(negedge clk);
      check("t6 no release", release_pulse, 0);
      #1 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("t6 no early press", press_pulse, 0);
      @(negedge clk);
      check("t6 press after reset", press_pulse, 3'b111);
      drive(3'b111);
      repeat (10) @(negedge clk);

      // Randomized bouncing keys with occasional reset pulses
      rate = 10;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         #1;
         if (c % 200 == 0) begin
            case ($urandom_range(2))
               0:       rate = 3;
               1:       rate = 10;
               default: rate = 60;
            endcase
         end
         for (int i = 0; i < N; i++)
            if ($urandom_range(rate - 1) == 0) key_raw[i] = ~key_raw[i];
         rst_n = ($urandom_range(999) != 0);
      end
      #1 rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
